// File: rtl/ahb_pkg.sv
// Shared AHB encodings and FSM state type for the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam hresp_e OKAY  = RESP_OKAY;
  localparam hresp_e ERROR = RESP_ERROR;

  // Low address bits that must be zero for a naturally aligned transfer.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane enable mask for an AHB transfer of a given size and lane offset.
module ahb_byte_strobe #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                   hsize,
  input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
  output logic [DATA_W/8-1:0]          strb
);

  // A lane is enabled when it sits in the same size-aligned block as the address.
  always_comb begin
    strb = '0;
    for (int unsigned i = 0; i < DATA_W / 8; i++)
      strb[i] = (i >> hsize) == (32'(addr_lo) >> hsize);
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8192,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = $clog2(DEPTH);

  state_e              state, state_nx;
  logic [2:0]          wait_cnt, wait_cnt_nx;
  logic [IDX_W-1:0]    idx_q;
  logic [LANE_W-1:0]   lane_q;
  logic [2:0]          size_q;
  logic                write_q;
  logic                valid_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [LANES-1:0]    strb;
  logic [ADDR_W-1:0]   word_addr;
  logic                phase_end, accept, legal;
  logic                oob, too_big, misalign;

  assign word_addr = HADDR >> LANE_W;
  assign oob       = 64'(word_addr) >= 64'(DEPTH);
  assign too_big   = HSIZE > 3'(LANE_W);
  assign misalign  = (HADDR[2:0] & align_mask(HSIZE)) != '0;
  assign legal     = !oob && !too_big && !misalign;

  // A new address phase can only land where the current data phase completes.
  assign phase_end = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
  assign accept    = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
                     && phase_end;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    HREADYOUT   = 1'b1;
    HRESP       = OKAY;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == '0) state_nx = ST_ACCESS;
        else                wait_cnt_nx = wait_cnt - 3'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: HRESP = ERROR;
      default: ;
    endcase
    if (phase_end) begin
      if (!accept)              state_nx = ST_IDLE;
      else if (!legal)          state_nx = ST_ERR1;
      else if (WAIT_STATES > 0) begin
        state_nx    = ST_WAIT;
        wait_cnt_nx = 3'(WAIT_STATES - 1);
      end
      else                      state_nx = ST_ACCESS;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (phase_end) valid_q <= accept && legal;
      if (accept && HTRANS == HTRANS_SEQ) assert (HBURST != 3'b000);
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      idx_q   <= HADDR[LANE_W +: IDX_W];
      lane_q  <= HADDR[LANE_W-1:0];
      size_q  <= HSIZE;
      write_q <= HWRITE;
    end
  end

  ahb_byte_strobe #(.DATA_W(DATA_W)) u_strobe (
    .hsize   (size_q),
    .addr_lo (lane_q),
    .strb    (strb)
  );

  // Reset gates the commit so a write aborted in its ACCESS cycle leaves memory intact.
  always_ff @(posedge HCLK) begin
    if (HRESETn && state == ST_ACCESS && valid_q && write_q)
      for (int unsigned i = 0; i < LANES; i++)
        if (strb[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end

  assign HRDATA = (state == ST_ACCESS && valid_q && !write_q) ? mem[idx_q] : '0;

endmodule
